// File: rtl/font_rom_arbiter_pkg.sv
// Shared font/game constants and ROM tag types for the font ROM arbiter.
// Used by font_rom_arbiter (optional stats build: FONT_ROM_ARB_STATS_EN).
package font_rom_arbiter_pkg;

    localparam int FONT_W         = 8;
    localparam int FONT_H         = 16;
    localparam int ADDR_W         = 10;
    localparam int FONT_LINESHIFT = 4;
    localparam int CNT_W          = 10;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_PRI  = 2'd1,
        TAG_SEC  = 2'd2
    } e_rom_tag_kind;

    typedef struct packed {
        e_rom_tag_kind      kind;
        logic [CNT_W-1:0]   idx;
    } st_rom_tag;

    localparam int TAG_W = $bits(st_rom_tag);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } e_arb_state;

    function automatic st_rom_tag mk_tag(input e_rom_tag_kind kind, input logic [CNT_W-1:0] idx);
        st_rom_tag t;
        t.kind = kind;
        t.idx  = idx;
        return t;
    endfunction

endpackage

// File: rtl/font_rom_arbiter_rom_tag_pipe.sv
// ROM_LAT-deep tag shift register tracking which requester owns each ROM read in flight.
// Reports whether any secondary read is still outstanding.
module font_rom_arbiter_rom_tag_pipe
    import font_rom_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic [TAG_W-1:0] tag_i,
    output logic [TAG_W-1:0] tag_o,
    output logic             sec_inflight_o
);

    st_rom_tag pipe_q [DEPTH];

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= mk_tag(TAG_NONE, '0);
            end
        end else begin
            pipe_q[0] <= st_rom_tag'(tag_i);
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_comb begin
        sec_inflight_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_q[i].kind == TAG_SEC) begin
                sec_inflight_o = 1'b1;
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/font_rom_arbiter.sv
// Font ROM arbiter: fixed-latency primary glyph fetch with idle-slot secondary bursts.
// Optional preemption counter output stall_cnt_o when FONT_ROM_ARB_STATS_EN is defined.
//
// state    | meaning
// ST_IDLE  | no burst; waiting for s_start
// ST_RUN   | issuing burst words in slots the renderer leaves free
// ST_DRAIN | all words issued; waiting for secondary reads to return
// ST_DONE  | one-cycle s_done pulse, then back to idle
module font_rom_arbiter
    import font_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int FONT_W  = 8,
    parameter int ROM_LAT = 1,
    parameter int CNT_W   = 10
) (
    input  logic              clk_sys,
    input  logic              rst_b,
    output logic              rom_clk_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [FONT_W-1:0] rom_q_i,
    input  logic              p_req_i,
    input  logic [ADDR_W-1:0] p_addr_i,
    output logic [FONT_W-1:0] p_q_o,
    output logic              p_valid_o,
    input  logic              s_start_i,
    input  logic [ADDR_W-1:0] s_base_i,
    input  logic [CNT_W-1:0]  s_count_i,
    output logic [FONT_W-1:0] s_data_o,
    output logic [CNT_W-1:0]  s_idx_o,
    output logic              s_valid_o,
    output logic              s_busy_o,
    output logic              s_done_o
`ifdef FONT_ROM_ARB_STATS_EN
   ,output logic [15:0]       stall_cnt_o
`endif
);

    e_arb_state        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] last_addr_q;
    logic [FONT_W-1:0] p_q_q, s_data_q;
    logic [CNT_W-1:0]  s_idx_q;
    logic              p_valid_q, s_valid_q;
    logic              sec_issue, start_ok, sec_inflight;
    st_rom_tag         tag_push, tag_out;
    logic [TAG_W-1:0]  tag_out_bits;

    assign rom_clk_o = clk_sys;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        sec_issue = 1'b0;
        start_ok  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_start_i) begin
                    start_ok = 1'b1;
                    if (s_count_i != '0) begin
                        ptr_d   = s_base_i;
                        rem_d   = s_count_i;
                        idx_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                // renderer owns the slot whenever it asks; the burst just waits
                if (!p_req_i) begin
                    sec_issue = 1'b1;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    idx_d     = idx_q + CNT_W'(1);
                    rem_d     = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!sec_inflight) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rom_addr_o = last_addr_q;
        tag_push   = mk_tag(TAG_NONE, '0);
        if (p_req_i) begin
            rom_addr_o = p_addr_i;
            tag_push   = mk_tag(TAG_PRI, '0);
        end else if (sec_issue) begin
            rom_addr_o = ptr_q;
            tag_push   = mk_tag(TAG_SEC, idx_q);
        end
    end

    font_rom_arbiter_rom_tag_pipe #(
        .DEPTH (ROM_LAT)
    ) u_tag_pipe (
        .clk_sys        (clk_sys),
        .rst_b          (rst_b),
        .tag_i          (tag_push),
        .tag_o          (tag_out_bits),
        .sec_inflight_o (sec_inflight)
    );

    assign tag_out = st_rom_tag'(tag_out_bits);

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            idx_q       <= '0;
            last_addr_q <= '0;
            p_q_q       <= '0;
            p_valid_q   <= 1'b0;
            s_data_q    <= '0;
            s_idx_q     <= '0;
            s_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            last_addr_q <= rom_addr_o;
            p_valid_q   <= (tag_out.kind == TAG_PRI);
            s_valid_q   <= (tag_out.kind == TAG_SEC);
            if (tag_out.kind == TAG_PRI) begin
                p_q_q <= rom_q_i;
            end
            if (tag_out.kind == TAG_SEC) begin
                s_data_q <= rom_q_i;
                s_idx_q  <= tag_out.idx;
            end
        end
    end

    assign p_q_o     = p_q_q;
    assign p_valid_o = p_valid_q;
    assign s_data_o  = s_data_q;
    assign s_idx_o   = s_idx_q;
    assign s_valid_o = s_valid_q;
    assign s_busy_o  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign s_done_o  = (state_q == ST_DONE);

`ifdef FONT_ROM_ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            stall_cnt_q <= '0;
        end else if (start_ok) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_RUN) && p_req_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Scoreboard bench for font_rom_arbiter with a behavioural ROM model.
// Checks stall_cnt_o as well when FONT_ROM_ARB_STATS_EN is defined.
module tb_font_rom_arbiter;

    localparam int ROM_LAT = 1;

    logic        clk_sys = 1'b0;
    logic        rst_b;
    logic        rom_clk;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_q;
    logic        p_req;
    logic [9:0]  p_addr;
    logic [7:0]  p_q;
    logic        p_valid;
    logic        s_start;
    logic [9:0]  s_base;
    logic [9:0]  s_count;
    logic [7:0]  s_data;
    logic [9:0]  s_idx;
    logic        s_valid;
    logic        s_busy;
    logic        s_done;
`ifdef FONT_ROM_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    font_rom_arbiter #(
        .ADDR_W (10), .FONT_W (8), .ROM_LAT (ROM_LAT), .CNT_W (10)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_b       (rst_b),
        .rom_clk_o   (rom_clk),
        .rom_addr_o  (rom_addr),
        .rom_q_i     (rom_q),
        .p_req_i     (p_req),
        .p_addr_i    (p_addr),
        .p_q_o       (p_q),
        .p_valid_o   (p_valid),
        .s_start_i   (s_start),
        .s_base_i    (s_base),
        .s_count_i   (s_count),
        .s_data_o    (s_data),
        .s_idx_o     (s_idx),
        .s_valid_o   (s_valid),
        .s_busy_o    (s_busy),
        .s_done_o    (s_done)
`ifdef FONT_ROM_ARB_STATS_EN
       ,.stall_cnt_o (stall_cnt)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    // ROM model: distinct-ish contents, ROM_LAT-clock synchronous read
    logic [7:0] rom_mem [1024];
    logic [7:0] rq_pipe [ROM_LAT];
    initial for (int a = 0; a < 1024; a++) rom_mem[a] = 8'(a * 29 + (a >> 5) * 7 + 3);
    always @(posedge rom_clk) begin
        rq_pipe[0] <= rom_mem[rom_addr];
        for (int i = 1; i < ROM_LAT; i++) rq_pipe[i] <= rq_pipe[i-1];
    end
    assign rom_q = rq_pipe[ROM_LAT-1];

    typedef struct { int cyc; logic [7:0] data; } pri_exp_t;
    typedef struct { int cyc; logic [9:0] idx; logic [7:0] data; } sec_exp_t;
    pri_exp_t pri_q[$];
    sec_exp_t sec_q[$];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int s_got = 0;
    int done_cnt = 0;
    int last_sv_cyc = 0;
    int sv_since_done = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk_sys) begin
        if (!rst_b) begin
            sv_since_done = 0;
        end else begin
            if (p_valid) begin
                check_eq("p_expected", pri_q.size() != 0, 1);
                if (pri_q.size() != 0) begin
                    pri_exp_t e;
                    e = pri_q.pop_front();
                    check_eq("p_latency", cyc, e.cyc);
                    check_eq("p_q", p_q, e.data);
                end
            end
            if (s_valid) begin
                check_eq("s_p_exclusive", p_valid, 0);
                check_eq("s_expected", sec_q.size() != 0, 1);
                if (sec_q.size() != 0) begin
                    sec_exp_t e;
                    e = sec_q.pop_front();
                    check_eq("s_idx", s_idx, e.idx);
                    check_eq("s_data", s_data, e.data);
                    if (e.cyc >= 0) check_eq("s_timing", cyc, e.cyc);
                end
                s_got++;
                last_sv_cyc = cyc;
                sv_since_done++;
            end
            if (s_done) begin
                done_cnt++;
                if (sv_since_done > 0) check_eq("done_gap", cyc - last_sv_cyc, 1);
                sv_since_done = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive_p(input logic [9:0] a);
        p_req  = 1'b1;
        p_addr = a;
        pri_q.push_back('{cyc + ROM_LAT + 1, rom_mem[a]});
    endtask

    task automatic start_burst(input logic [9:0] base, input logic [9:0] cnt, input bit timed);
        s_start = 1'b1;
        s_base  = base;
        s_count = cnt;
        for (int i = 0; i < int'(cnt); i++) begin
            logic [9:0] a;
            a = base + 10'(i);
            sec_q.push_back('{timed ? cyc + ROM_LAT + 2 + i : -1, 10'(i), rom_mem[a]});
        end
    endtask

    task automatic wait_burst(input int max_cyc);
        int n = 0;
        while ((sec_q.size() != 0 || s_busy) && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq("burst_drained", sec_q.size(), 0);
        check_eq("busy_cleared", s_busy, 0);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, g0, g1, issued, stall;
        logic [9:0] a0;
        logic [9:0] wexp [3];

        rst_b = 1'b0; p_req = 1'b0; p_addr = '0;
        s_start = 1'b0; s_base = '0; s_count = '0;
        repeat (3) tick();
        check_eq("rst_rom_addr", rom_addr, 0);
        check_eq("rst_p_q", p_q, 0);
        check_eq("rst_p_valid", p_valid, 0);
        check_eq("rst_s_data", s_data, 0);
        check_eq("rst_s_idx", s_idx, 0);
        check_eq("rst_s_valid", s_valid, 0);
        check_eq("rst_s_busy", s_busy, 0);
        check_eq("rst_s_done", s_done, 0);
        rst_b = 1'b1;

        // primary fetch alone, then hold
        while (cyc < 10) tick();
        drive_p(10'h041);
        tick();
        p_req = 1'b0;
        while (cyc < 40) tick();
        @(negedge clk_sys);
        check_eq("p_hold", p_q, rom_mem[10'h041]);
        check_eq("p_all_returned", pri_q.size(), 0);
        tick();

        // burst with the ROM otherwise idle
        d0 = done_cnt;
        start_burst(10'h100, 10'd4, 1'b1);
        tick();
        s_start = 1'b0;
        @(negedge clk_sys);
        check_eq("busy_in_run", s_busy, 1);
        tick();
        wait_burst(40);
        check_eq("idle_done_once", done_cnt - d0, 1);

        // burst preempted by a fetch every third cycle
        d0 = done_cnt;
        start_burst(10'h200, 10'd8, 1'b0);
        issued = 0;
        stall = 0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            s_start = 1'b0;
            if (t % 3 == 0) drive_p(10'($urandom_range(0, 1023)));
            else p_req = 1'b0;
            if (issued < 8) begin
                if (p_req) stall++;
                else issued++;
            end
        end
        tick();
        p_req = 1'b0;
        wait_burst(60);
        check_eq("pre_done_once", done_cnt - d0, 1);
        check_eq("pre_pri_returned", pri_q.size(), 0);
`ifdef FONT_ROM_ARB_STATS_EN
        check_eq("stall_cnt", stall_cnt, stall);
`endif

        // address wrap at the top of the ROM
        wexp[0] = 10'h3FE; wexp[1] = 10'h3FF; wexp[2] = 10'h000;
        start_burst(10'h3FE, 10'd3, 1'b1);
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            check_eq("wrap_addr", rom_addr, wexp[i]);
            tick();
        end
        wait_burst(40);

        // zero-length burst
        a0 = rom_addr;
        g0 = s_got;
        d0 = done_cnt;
        s_start = 1'b1; s_base = 10'h155; s_count = 10'd0;
        tick();
        s_start = 1'b0;
        @(negedge clk_sys);
        check_eq("zero_done", s_done, 1);
        check_eq("zero_addr", rom_addr, a0);
        repeat (4) tick();
        check_eq("zero_no_data", s_got - g0, 0);
        check_eq("zero_done_once", done_cnt - d0, 1);

        // reset in the middle of a burst
        g0 = s_got;
        start_burst(10'h080, 10'd6, 1'b1);
        tick();
        s_start = 1'b0;
        for (int n = 0; n < 50 && (s_got - g0) < 2; n++) @(negedge clk_sys);
        check_eq("rst_mid_words", s_got - g0, 2);
        tick();
        rst_b = 1'b0;
        #1;
        check_eq("rstm_s_busy", s_busy, 0);
        check_eq("rstm_s_valid", s_valid, 0);
        check_eq("rstm_s_done", s_done, 0);
        check_eq("rstm_s_data", s_data, 0);
        check_eq("rstm_s_idx", s_idx, 0);
        check_eq("rstm_p_q", p_q, 0);
        check_eq("rstm_rom_addr", rom_addr, 0);
        sec_q.delete();
        d0 = done_cnt;
        g1 = s_got;
        repeat (2) tick();
        rst_b = 1'b1;
        repeat (10) tick();
        check_eq("rstm_no_valid", s_got - g1, 0);
        check_eq("rstm_no_done", done_cnt - d0, 0);
        start_burst(10'h010, 10'd2, 1'b1);
        tick();
        s_start = 1'b0;
        wait_burst(40);
        check_eq("rstm_restart_done", done_cnt - d0, 1);

        // s_start while busy must not disturb the running burst
        d0 = done_cnt;
        g0 = s_got;
        start_burst(10'h300, 10'd5, 1'b1);
        tick();
        s_start = 1'b0;
        tick();
        s_start = 1'b1; s_base = 10'h000; s_count = 10'd7;
        tick();
        s_start = 1'b0;
        wait_burst(40);
        check_eq("restart_words", s_got - g0, 5);
        check_eq("restart_done_once", done_cnt - d0, 1);
        repeat (5) tick();
        check_eq("restart_idle", s_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
